// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: register offsets, the
// arbitration FSM encoding and the hardware interrupt line range IP[7:2].
package interrupt_arbiter_pkg;

    // Interrupt line range handled by this block (CP0 IP[7:2]).
    localparam int IRQ_LO  = 2;
    localparam int IRQ_HI  = 7;
    localparam int NUM_IRQ = IRQ_HI - IRQ_LO + 1;

    // Register select values on PrAddr.
    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_VECTOR  = 2'd3;

    // Arbitration FSM: IDLE looks for a winner, ASSERT holds it until
    // acknowledged or until the winner stops being eligible.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } arb_state_e;

    // One-hot line vector for an interrupt index in IRQ_LO..IRQ_HI.
    // Indices outside the range give an all-zero vector.
    function automatic logic [NUM_IRQ-1:0] irq_onehot(input logic [2:0] idx);
        logic [NUM_IRQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (idx == 3'(i + IRQ_LO)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Places a per-line register at bit positions [7:2] of a read word.
    function automatic logic [31:0] reg_word(input logic [NUM_IRQ-1:0] bits);
        return {24'd0, bits, 2'b00};
    endfunction

endpackage

// File: rtl/interrupt_arbiter_prio_enc.sv
// Fixed-priority encoder for the eligible interrupt lines.
// Bit 0 of the vector is IP2 and has the highest priority; the index is
// reported in interrupt-line numbering (2..7).
module irq_prio_enc
    import interrupt_arbiter_pkg::*;
(
    input  logic [NUM_IRQ-1:0] i_eligible,
    output logic [2:0]         o_index,
    output logic               o_valid
);

    // Scan from the lowest-priority line upward so the lowest index wins.
    always_comb begin
        o_index = '0;
        o_valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_index = 3'(i + IRQ_LO);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter for CP0 lines IP[7:2].
// Holds MASK / PENDING / MODE registers, detects edges on edge-mode lines,
// picks the highest-priority eligible line and drives a registered one-hot
// request to CP0 until software acknowledges it or it stops being eligible.
//
// Register bus: WE is a single-cycle write strobe qualified by PrAddr; there
// is no back-pressure, every strobe is accepted on the clock edge it is seen.
// Reads are combinational on PrAddr and have no side effects; the ACK is a
// write to the VECTOR offset (data ignored).
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PrAddr,
    input  logic        WE,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    input  logic [7:2]  DevInterruptRequest,
    output logic [7:2]  CP0InterruptRequest
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_prev;
    logic [2:0]         r_winner;
    logic [NUM_IRQ-1:0] r_cp0;
    arb_state_e         r_state;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] w_raw;
    logic [NUM_IRQ-1:0] w_wdata;
    logic               w_wr_mask;
    logic               w_wr_pend;
    logic               w_wr_mode;
    logic               w_ack;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_winner_oh;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pend_next;
    logic [NUM_IRQ-1:0] w_eligible;
    logic               w_winner_elig;
    logic [2:0]         w_enc_index;
    logic               w_enc_valid;
    arb_state_e         w_state_next;
    logic [2:0]         w_winner_next;
    logic [NUM_IRQ-1:0] w_cp0_next;
    logic               w_unused_data;

    assign w_raw   = DevInterruptRequest;
    assign w_wdata = DataIn[IRQ_HI:IRQ_LO];

    // Only DataIn[7:2] carries register content.
    assign w_unused_data = ^{DataIn[31:IRQ_HI+1], DataIn[IRQ_LO-1:0]};

    // Decode of the register write strobe.
    assign w_wr_mask = WE && (PrAddr == ADDR_MASK);
    assign w_wr_pend = WE && (PrAddr == ADDR_PENDING);
    assign w_wr_mode = WE && (PrAddr == ADDR_MODE);

    // An ACK only means something while a request is being presented.
    assign w_ack = WE && (PrAddr == ADDR_VECTOR) && (r_state == ST_ASSERT);

    // ------------------------------------------------------------------
    // Pending logic
    // ------------------------------------------------------------------
    assign w_rise      = w_raw & ~r_prev;
    assign w_winner_oh = irq_onehot(r_winner);

    // Clear sources for edge-mode lines: write-1-to-clear and ACK of the winner.
    assign w_clr = (w_wr_pend ? w_wdata : '0) | (w_ack ? w_winner_oh : '0);

    // Edge lines: a rising edge sets and beats any clear in the same cycle.
    // Level lines: simply follow the raw request, so clears cannot stick.
    assign w_pend_next = (r_mode & (w_rise | (r_pend & ~w_clr)))
                       | (~r_mode & w_raw);

    assign w_eligible    = r_pend & r_mask;
    assign w_winner_elig = |(w_eligible & w_winner_oh);

    irq_prio_enc u_prio_enc (
        .i_eligible (w_eligible),
        .o_index    (w_enc_index),
        .o_valid    (w_enc_valid)
    );

    // Configuration, pending and edge-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_mode <= '0;
            r_pend <= '0;
            r_prev <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= w_wdata;
            end
            if (w_wr_mode) begin
                r_mode <= w_wdata;
            end
            r_pend <= w_pend_next;
            r_prev <= w_raw;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: the winner is never preempted while presented; it is
    // released by ACK or by losing eligibility.  Every release passes through
    // IDLE, which guarantees a zero cycle on the CP0 request.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_enc_valid) begin
                    w_state_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (w_ack || !w_winner_elig) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: winner is latched only when leaving IDLE, and the CP0
    // request for the next cycle is the one-hot of that winner.
    always_comb begin
        w_winner_next = r_winner;
        if ((r_state == ST_IDLE) && w_enc_valid) begin
            w_winner_next = w_enc_index;
        end
        w_cp0_next = '0;
        if (w_state_next == ST_ASSERT) begin
            w_cp0_next = irq_onehot(w_winner_next);
        end
    end

    // Registered winner index and CP0 request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winner <= '0;
            r_cp0    <= '0;
        end else begin
            r_winner <= w_winner_next;
            r_cp0    <= w_cp0_next;
        end
    end

    assign CP0InterruptRequest = r_cp0;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------

    // Combinational register read; VECTOR reports state and winner only
    // while a request is presented.
    always_comb begin
        DataOut = '0;
        case (PrAddr)
            ADDR_MASK:    DataOut = reg_word(r_mask);
            ADDR_PENDING: DataOut = reg_word(r_pend);
            ADDR_MODE:    DataOut = reg_word(r_mode);
            ADDR_VECTOR: begin
                if (r_state == ST_ASSERT) begin
                    DataOut = {1'b1, 28'd0, r_winner};
                end
            end
            default: DataOut = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: a line-level reference model checked
// against the DUT every cycle, plus hand-computed checkpoints.
module tb_interrupt_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  pr_addr;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [7:2]  dev_irq;
  logic [7:2]  cp0;

  int n_checks = 0;
  int n_bad    = 0;
  bit chk_en   = 0;

  interrupt_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .PrAddr              (pr_addr),
    .WE                  (we),
    .DataIn              (data_in),
    .DataOut             (data_out),
    .DevInterruptRequest (dev_irq),
    .CP0InterruptRequest (cp0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------
  // reference model, line numbers 2..7 stored at index line-2
  // ---------------------------------------------------------------
  bit m_mask[6];
  bit m_mode[6];
  bit m_pend[6];
  bit m_prev[6];
  bit m_on;
  int m_win;

  always @(posedge clk) begin : model
    bit np[6];
    bit ack;
    bit rise;
    bit clr;
    int found;
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        m_mask[i] = 0; m_mode[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
      end
      m_on  = 0;
      m_win = 0;
    end else begin
      ack = we && (pr_addr == 2'd3) && m_on;
      for (int i = 0; i < 6; i++) begin
        rise = dev_irq[i+2] && !m_prev[i];
        if (m_mode[i]) begin
          clr = (we && pr_addr == 2'd1 && data_in[i+2]) || (ack && m_win == i + 2);
          np[i] = rise || (m_pend[i] && !clr);
        end else begin
          np[i] = dev_irq[i+2];
        end
      end
      if (!m_on) begin
        found = -1;
        for (int i = 5; i >= 0; i--) if (m_pend[i] && m_mask[i]) found = i;
        if (found >= 0) begin
          m_on  = 1;
          m_win = found + 2;
        end
      end else if (ack || !(m_pend[m_win-2] && m_mask[m_win-2])) begin
        m_on = 0;
      end
      for (int i = 0; i < 6; i++) begin
        if (we && pr_addr == 2'd0) m_mask[i] = data_in[i+2];
        if (we && pr_addr == 2'd2) m_mode[i] = data_in[i+2];
        m_prev[i] = dev_irq[i+2];
        m_pend[i] = np[i];
      end
    end
  end

  function automatic logic [7:0] exp_cp0();
    logic [7:0] v;
    v = 8'd0;
    if (m_on) v[m_win] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] exp_dout(input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 6; i++) begin
      case (a)
        2'd0: v[i+2] = m_mask[i];
        2'd1: v[i+2] = m_pend[i];
        2'd2: v[i+2] = m_mode[i];
        default: ;
      endcase
    end
    if (a == 2'd3 && m_on) v = 32'h8000_0000 | 32'(m_win);
    return v;
  endfunction

  // scoreboard check
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_cp0", {24'd0, cp0, 2'b00}, {24'd0, exp_cp0()});
      check("cycle_dout", data_out, exp_dout(pr_addr));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #3;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    pr_addr = a;
    data_in = d;
    we      = 1'b1;
    tick();
    we      = 1'b0;
    data_in = 32'd0;
  endtask

  function automatic logic [31:0] cpw();
    return {24'd0, cp0, 2'b00};
  endfunction

  // watchdog
  initial begin
    #20000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    reset = 1'b1; we = 1'b0; pr_addr = 2'd0; data_in = 32'd0; dev_irq = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1;
    peek();
    check("rst_cp0", cpw(), 32'h0);
    check("rst_mask", data_out, 32'h0);

    // edge IP2: request two cycles after the raw edge
    wr(2'd0, 32'h84);
    wr(2'd2, 32'h04);
    dev_irq[2] = 1'b1;
    tick();
    dev_irq[2] = 1'b0;
    pr_addr = 2'd1;
    peek();
    check("lat_n1_cp0", cpw(), 32'h0);
    check("lat_n1_pend", data_out, 32'h04);
    tick();
    pr_addr = 2'd3;
    peek();
    check("ip2_cp0", cpw(), 32'h04);
    check("ip2_vector", data_out, 32'h8000_0002);

    // IP7 arrives while IP2 presented: no preemption, gap after ACK
    dev_irq[7] = 1'b1;
    tick();
    tick();
    peek();
    check("no_preempt", cpw(), 32'h04);
    wr(2'd3, 32'hFFFF_FFFF);
    peek();
    check("ack_gap", cpw(), 32'h0);
    tick();
    peek();
    check("ip7_cp0", cpw(), 32'h80);
    check("ip7_vector", data_out, 32'h8000_0007);
    dev_irq[7] = 1'b0;
    tick();
    tick();
    tick();
    peek();
    check("ip7_drop", cpw(), 32'h0);

    // edge on IP3 together with W1C of IP3: set wins
    wr(2'd2, 32'h0C);
    dev_irq[3] = 1'b1;
    pr_addr = 2'd1;
    data_in = 32'h08;
    we = 1'b1;
    tick();
    we = 1'b0;
    data_in = 32'd0;
    dev_irq[3] = 1'b0;
    peek();
    check("set_wins", data_out, 32'h08);
    wr(2'd1, 32'h08);
    peek();
    check("w1c_clears", data_out, 32'h0);

    // level IP5 held then dropped before ACK
    wr(2'd0, 32'h20);
    dev_irq[5] = 1'b1;
    tick();
    tick();
    peek();
    check("lvl5_on", cpw(), 32'h20);
    dev_irq[5] = 1'b0;
    tick();
    tick();
    pr_addr = 2'd3;
    peek();
    check("lvl5_off", cpw(), 32'h0);
    check("lvl5_vector", data_out, 32'h0);

    // edge IP6 presented, then its mask bit cleared
    wr(2'd2, 32'h4C);
    wr(2'd0, 32'h40);
    dev_irq[6] = 1'b1;
    tick();
    dev_irq[6] = 1'b0;
    tick();
    peek();
    check("ip6_on", cpw(), 32'h40);
    wr(2'd0, 32'h0);
    pr_addr = 2'd1;
    tick();
    peek();
    check("unmask_off", cpw(), 32'h0);
    check("unmask_pend", data_out, 32'h40);

    // reset while IP4 held high
    wr(2'd0, 32'h10);
    dev_irq[4] = 1'b1;
    tick();
    tick();
    peek();
    check("ip4_on", cpw(), 32'h10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pr_addr = 2'd1;
    peek();
    check("rst_mid_cp0", cpw(), 32'h0);
    check("rst_mid_pend", data_out, 32'h0);
    wr(2'd2, 32'h10);
    wr(2'd1, 32'h10);
    wr(2'd0, 32'h10);
    tick();
    pr_addr = 2'd1;
    tick();
    peek();
    check("held_no_edge", cpw(), 32'h0);
    check("held_no_pend", data_out, 32'h0);
    dev_irq[4] = 1'b0;
    tick();
    dev_irq[4] = 1'b1;
    tick();
    tick();
    peek();
    check("ip4_rearm", cpw(), 32'h10);

    tick();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 Parameter: none; line range is fixed at IP[7:2] (6 lines).
REQ-002 clk  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PrAddr  input  2  register select: 0 MASK, 1 PENDING, 2 MODE, 3 VECTOR/ACK.
REQ-005 WE  input  1  register write strobe from the bridge, one cycle per write.
REQ-006 DataIn  input  32  write data.
REQ-007 DataOut  output  32  read data for PrAddr; combinational.
REQ-008 DevInterruptRequest  input  6 [7:2]  raw device requests, same clock domain, not synchronized.
REQ-009 CP0InterruptRequest  output  6 [7:2]  registered one-hot request to CP0.

Function
REQ-010 MASK[7:2] (RW, DataIn[7:2]): 1 enables the line; other bits read 0.
REQ-011 MODE[7:2] (RW, DataIn[7:2]): 1 = edge-triggered, 0 = level-triggered.
REQ-012 Edge detection uses a 6-bit previous-value register; rising edge = raw & ~prev.
REQ-013 Edge line: PENDING bit sets on the rising edge and holds until write-1-to-clear or ACK.
REQ-014 Level line: PENDING bit is registered copy of the raw line each cycle; W1C and ACK have no lasting effect.
REQ-015 PENDING write: DataIn[7:2] bits of 1 clear the corresponding edge-mode bits.
REQ-016 Set wins over clear: an edge in the same cycle as W1C or ACK on that line leaves PENDING=1.
REQ-017 Eligible = PENDING & MASK; priority: lowest index highest (IP2 > IP3 > ... > IP7).
REQ-018 FSM states: IDLE, ASSERT.
REQ-019 IDLE: if eligible nonzero, latch winner index, go to ASSERT; CP0InterruptRequest = one-hot(winner) from the next cycle.
REQ-020 Latency: raw rising edge at cycle N -> PENDING at N+1 -> CP0InterruptRequest at N+2.
REQ-021 ASSERT: winner is frozen; a higher-priority arrival does not preempt.
REQ-022 ASSERT exits to IDLE on a write to PrAddr 3 (ACK, data ignored); winner's PENDING clears if edge mode (subject to REQ-016).
REQ-023 ASSERT also exits to IDLE if the winner's eligible bit falls (mask cleared, W1C, level line dropped).
REQ-024 On any ASSERT->IDLE transition, CP0InterruptRequest is 0 for at least one cycle before the next assertion.
REQ-025 VECTOR read: DataOut[31] = (state==ASSERT), DataOut[2:0] = winner index (2..7) when in ASSERT, all other bits 0.
REQ-026 Write to MASK/MODE in ASSERT takes effect next cycle and is evaluated per REQ-023.

Reset
REQ-027 Reset SHALL set MASK=0, MODE=0, PENDING=0, prev=0, winner=0, state=IDLE, CP0InterruptRequest=0.
REQ-028 Reset mid-ASSERT drops CP0InterruptRequest to 0 on the next edge; a pending edge is lost.
REQ-029 After reset, a line held high is not seen as an edge until it falls and rises again.

Structure
REQ-030 Shared package holds register offsets (MASK=0, PENDING=1, MODE=2, VECTOR=3), state encoding, IRQ_LO=2, IRQ_HI=7.
REQ-031 One sub-module irq_prio_enc: 6-bit eligible vector -> 3-bit index plus valid, combinational.
REQ-032 The bridge maps this block at 0x7F20-0x7F2F and routes CP0InterruptRequest to CP0.

Verification
REQ-033 Reset, MASK=0x84, MODE=0x04, pulse IP2 at N -> CP0InterruptRequest=0x04 (bit 2) at N+2; VECTOR reads 0x80000002.
REQ-034 In ASSERT on IP2, raise IP7 (masked in) -> output stays bit 2; ACK -> 0 for one cycle, then bit 7.
REQ-035 Edge on IP3 in the same cycle as PENDING W1C 0x08 -> PENDING[3] stays 1.
REQ-036 Level IP5 masked in, held high -> assert; drop IP5 before ACK -> return to IDLE, output 0, VECTOR[31]=0.
REQ-037 Clear MASK bit of winner during ASSERT -> output 0 within 2 cycles; PENDING bit retained (edge mode).
REQ-038 Reset while asserted with IP4 held high -> output 0, PENDING 0; no request until IP4 falls and rises again.
